// File: rtl/config_frame_loader.sv
// Configuration word stream loader: hunts for the sync word, decodes frame headers,
// broadcasts per-row frame data with a row select, and closes each frame with a strobe.
module config_frame_loader #(
    parameter int          FrameBitsPerRow  = 32,
    parameter int          RowSelectWidth   = 5,
    parameter int          NumberOfRows     = 12,
    parameter int          FrameSelectWidth = 5,
    parameter int          MaxFramesPerCol  = 20,
    parameter logic [31:0] SyncPattern      = 32'hFAB0_FAB1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [31:0]                 WordData_I,
    input  logic                        WordValid_I,
    output logic                        WordReady_O,
    output logic [FrameBitsPerRow-1:0]  FrameData_O,
    output logic [RowSelectWidth-1:0]   RowSelect_O,
    output logic                        FrameStrobe_O,
    output logic [FrameSelectWidth-1:0] FrameAddr_O,
    output logic                        Busy_O,
    output logic                        Error_O
);

    localparam int ROW_W = $clog2(NumberOfRows + 1);
    localparam logic [ROW_W-1:0]            LAST_ROW  = ROW_W'(NumberOfRows);
    localparam logic [ROW_W-1:0]            FIRST_ROW = ROW_W'(1'b1);
    localparam logic [FrameSelectWidth-1:0] MAX_ADDR  = FrameSelectWidth'(MaxFramesPerCol);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [FrameBitsPerRow-1:0]  frame_data_q, frame_data_d;
    logic [RowSelectWidth-1:0]   row_select_q, row_select_d;
    logic                        frame_strobe_q, frame_strobe_d;
    logic [FrameSelectWidth-1:0] frame_addr_q, frame_addr_d;
    logic                        busy_q, busy_d;
    logic                        error_q, error_d;
    logic                        word_ready_s;
    logic                        accept_s;
    logic [FrameSelectWidth-1:0] hdr_addr_s;

    assign word_ready_s = (state_q != ST_STROBE);
    assign accept_s     = WordValid_I & word_ready_s;
    assign hdr_addr_s   = WordData_I[FrameSelectWidth-1:0];

    // Next-state and output decode for the loader FSM.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        frame_data_d   = frame_data_q;
        row_select_d   = {RowSelectWidth{1'b0}};
        frame_addr_d   = frame_addr_q;
        error_d        = error_q;
        // The strobe trails the STROBE state by one edge so it follows the last row's cycle.
        frame_strobe_d = (state_q == ST_STROBE);

        case (state_q)
            ST_HUNT: begin
                if (accept_s && (WordData_I == SyncPattern)) begin
                    state_d = ST_HEADER;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_HEADER: begin
                if (!accept_s) begin
                    state_d = ST_HEADER;
                end else if (WordData_I[31]) begin
                    state_d = ST_HUNT;
                end else if (hdr_addr_s >= MAX_ADDR) begin
                    error_d = 1'b1;
                    state_d = ST_HUNT;
                end else begin
                    frame_addr_d = hdr_addr_s;
                    row_d        = FIRST_ROW;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    frame_data_d = WordData_I[FrameBitsPerRow-1:0];
                    row_select_d = RowSelectWidth'(row_q);
                    if (row_q == LAST_ROW) begin
                        state_d = ST_STROBE;
                    end else begin
                        row_d = row_q + FIRST_ROW;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STROBE: begin
                state_d = ST_HEADER;
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        busy_d = (state_d != ST_HUNT);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_HUNT;
            row_q          <= FIRST_ROW;
            frame_data_q   <= {FrameBitsPerRow{1'b0}};
            row_select_q   <= {RowSelectWidth{1'b0}};
            frame_strobe_q <= 1'b0;
            frame_addr_q   <= {FrameSelectWidth{1'b0}};
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            frame_data_q   <= frame_data_d;
            row_select_q   <= row_select_d;
            frame_strobe_q <= frame_strobe_d;
            frame_addr_q   <= frame_addr_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
        end
    end

    assign WordReady_O   = word_ready_s & ~RST;
    assign FrameData_O   = frame_data_q;
    assign RowSelect_O   = row_select_q;
    assign FrameStrobe_O = frame_strobe_q;
    assign FrameAddr_O   = frame_addr_q;
    assign Busy_O        = busy_q;
    assign Error_O       = error_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed self-checking bench for config_frame_loader: sync hunt, frame loading,
// valid gaps, illegal addresses, desync, mid-frame reset and back-to-back frames.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] WordData_I;
    logic        WordValid_I;
    logic        WordReady_O;
    logic [31:0] FrameData_O;
    logic [4:0]  RowSelect_O;
    logic        FrameStrobe_O;
    logic [4:0]  FrameAddr_O;
    logic        Busy_O;
    logic        Error_O;

    int tests = 0;
    int fails = 0;

    config_frame_loader dut (
        .CLK          (CLK),
        .RST          (RST),
        .WordData_I   (WordData_I),
        .WordValid_I  (WordValid_I),
        .WordReady_O  (WordReady_O),
        .FrameData_O  (FrameData_O),
        .RowSelect_O  (RowSelect_O),
        .FrameStrobe_O(FrameStrobe_O),
        .FrameAddr_O  (FrameAddr_O),
        .Busy_O       (Busy_O),
        .Error_O      (Error_O)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word for a single edge, then drop valid.
    task automatic put(input logic [31:0] w);
        WordValid_I = 1'b1;
        WordData_I  = w;
        tick();
        WordValid_I = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; WordValid_I = 1'b0; WordData_I = 32'h0;
        tick(); tick();
        tests++;
        if ({FrameData_O, RowSelect_O, FrameStrobe_O, FrameAddr_O, Busy_O, Error_O, WordReady_O} !== 46'h0) begin
            $display("FAIL reset_outputs: got data=%h row=%0d strb=%b addr=%0d busy=%b err=%b rdy=%b, expected all 0",
                     FrameData_O, RowSelect_O, FrameStrobe_O, FrameAddr_O, Busy_O, Error_O, WordReady_O);
            fails++;
        end
        RST = 1'b0;
        #1;
        tests++;
        if (WordReady_O !== 1'b1) begin
            $display("FAIL reset_ready_hunt: got %b, expected 1", WordReady_O); fails++;
        end
    endtask

    task automatic test_frame();
        logic [36:0] exp;
        put(SYNC);
        tests++;
        if ({Busy_O, RowSelect_O} !== {1'b1, 5'd0}) begin
            $display("FAIL t1_sync: got busy=%b row=%0d, expected busy=1 row=0", Busy_O, RowSelect_O); fails++;
        end
        put(32'h0000_0003);
        tests++;
        if ({Busy_O, FrameAddr_O} !== {1'b1, 5'd3}) begin
            $display("FAIL t1_header: got busy=%b addr=%0d, expected busy=1 addr=3", Busy_O, FrameAddr_O); fails++;
        end
        for (int i = 0; i < 12; i++) begin
            put(32'h100 + 32'(i));
            exp = {5'(i + 1), 32'h100 + 32'(i)};
            tests++;
            if ({RowSelect_O, FrameData_O} !== exp || FrameStrobe_O !== 1'b0) begin
                $display("FAIL t1_row: got row=%0d data=%h strb=%b, expected row=%0d data=%h strb=0",
                         RowSelect_O, FrameData_O, FrameStrobe_O, exp[36:32], exp[31:0]); fails++;
            end
        end
        tests++;
        if (WordReady_O !== 1'b0) begin
            $display("FAIL t1_ready_strobe_state: got %b, expected 0", WordReady_O); fails++;
        end
        tick();
        tests++;
        if ({FrameStrobe_O, FrameAddr_O, RowSelect_O, WordReady_O} !== {1'b1, 5'd3, 5'd0, 1'b1}) begin
            $display("FAIL t1_strobe: got strb=%b addr=%0d row=%0d rdy=%b, expected strb=1 addr=3 row=0 rdy=1",
                     FrameStrobe_O, FrameAddr_O, RowSelect_O, WordReady_O); fails++;
        end
        tick();
        tests++;
        if ({FrameStrobe_O, Busy_O} !== 2'b01) begin
            $display("FAIL t1_after_strobe: got strb=%b busy=%b, expected strb=0 busy=1", FrameStrobe_O, Busy_O); fails++;
        end
    endtask

    task automatic test_gaps();
        int strobes = 0;
        logic [36:0] exp;
        put(32'h0000_0003);
        for (int i = 0; i < 12; i++) begin
            put(32'h100 + 32'(i));
            exp = {5'(i + 1), 32'h100 + 32'(i)};
            strobes += int'(FrameStrobe_O);
            tests++;
            if ({RowSelect_O, FrameData_O} !== exp) begin
                $display("FAIL t2_row: got row=%0d data=%h, expected row=%0d data=%h",
                         RowSelect_O, FrameData_O, exp[36:32], exp[31:0]); fails++;
            end
            for (int g = 0; g < 2; g++) begin
                tick();
                strobes += int'(FrameStrobe_O);
                tests++;
                if ({RowSelect_O, FrameData_O} !== {5'd0, exp[31:0]}) begin
                    $display("FAIL t2_gap: got row=%0d data=%h, expected row=0 data=%h",
                             RowSelect_O, FrameData_O, exp[31:0]); fails++;
                end
            end
        end
        tick(); strobes += int'(FrameStrobe_O);
        tick(); strobes += int'(FrameStrobe_O);
        tests++;
        if (strobes != 1) begin
            $display("FAIL t2_strobe_count: got %0d, expected 1", strobes); fails++;
        end
    endtask

    task automatic test_bad_addr();
        RST = 1'b1; tick(); RST = 1'b0;
        put(SYNC);
        put(32'h0000_0019);
        tests++;
        if ({Error_O, Busy_O, RowSelect_O, FrameStrobe_O} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            $display("FAIL t3_err: got err=%b busy=%b row=%0d strb=%b, expected err=1 busy=0 row=0 strb=0",
                     Error_O, Busy_O, RowSelect_O, FrameStrobe_O); fails++;
        end
        put(SYNC);
        put(32'h0000_0014);
        tests++;
        if ({Error_O, Busy_O} !== 2'b10) begin
            $display("FAIL t3_addr20: got err=%b busy=%b, expected err=1 busy=0", Error_O, Busy_O); fails++;
        end
        put(SYNC);
        put(32'h0000_0000);
        tests++;
        if ({Busy_O, FrameAddr_O} !== {1'b1, 5'd0}) begin
            $display("FAIL t3_header0: got busy=%b addr=%0d, expected busy=1 addr=0", Busy_O, FrameAddr_O); fails++;
        end
        for (int i = 0; i < 12; i++) begin
            put(32'h200 + 32'(i));
        end
        tests++;
        if ({RowSelect_O, FrameData_O} !== {5'd12, 32'h20B}) begin
            $display("FAIL t3_last_row: got row=%0d data=%h, expected row=12 data=0000020b", RowSelect_O, FrameData_O); fails++;
        end
        tick();
        tests++;
        if ({FrameStrobe_O, FrameAddr_O, Error_O} !== {1'b1, 5'd0, 1'b1}) begin
            $display("FAIL t3_strobe: got strb=%b addr=%0d err=%b, expected strb=1 addr=0 err=1",
                     FrameStrobe_O, FrameAddr_O, Error_O); fails++;
        end
    endtask

    task automatic test_desync();
        put(32'h8000_0000);
        tests++;
        if (Busy_O !== 1'b0) begin
            $display("FAIL t4_desync_hdr: got busy=%b, expected 0", Busy_O); fails++;
        end
        put(SYNC);
        put(32'h8000_0000);
        tests++;
        if (Busy_O !== 1'b0) begin
            $display("FAIL t4_desync: got busy=%b, expected 0", Busy_O); fails++;
        end
        put(32'h1234_5678);
        tests++;
        if ({Busy_O, RowSelect_O, FrameData_O} !== {1'b0, 5'd0, 32'h20B}) begin
            $display("FAIL t4_ignored: got busy=%b row=%0d data=%h, expected busy=0 row=0 data=0000020b",
                     Busy_O, RowSelect_O, FrameData_O); fails++;
        end
        put(32'h0000_0005);
        tests++;
        if ({Busy_O, FrameAddr_O} !== {1'b0, 5'd0}) begin
            $display("FAIL t4_hunt_header: got busy=%b addr=%0d, expected busy=0 addr=0", Busy_O, FrameAddr_O); fails++;
        end
    endtask

    task automatic test_mid_reset();
        put(SYNC);
        put(32'h0000_0013);
        tests++;
        if ({Busy_O, FrameAddr_O} !== {1'b1, 5'd19}) begin
            $display("FAIL t5_addr19: got busy=%b addr=%0d, expected busy=1 addr=19", Busy_O, FrameAddr_O); fails++;
        end
        for (int i = 0; i < 5; i++) begin
            put(32'h300 + 32'(i));
        end
        tests++;
        if ({RowSelect_O, FrameData_O} !== {5'd5, 32'h304}) begin
            $display("FAIL t5_row5: got row=%0d data=%h, expected row=5 data=00000304", RowSelect_O, FrameData_O); fails++;
        end
        RST = 1'b1; WordValid_I = 1'b1; WordData_I = 32'h305;
        tick();
        tests++;
        if ({FrameData_O, RowSelect_O, FrameStrobe_O, FrameAddr_O, Busy_O, Error_O, WordReady_O} !== 46'h0) begin
            $display("FAIL t5_reset: got data=%h row=%0d strb=%b addr=%0d busy=%b err=%b rdy=%b, expected all 0",
                     FrameData_O, RowSelect_O, FrameStrobe_O, FrameAddr_O, Busy_O, Error_O, WordReady_O); fails++;
        end
        RST = 1'b0; WordValid_I = 1'b0;
        for (int i = 6; i < 12; i++) begin
            put(32'h300 + 32'(i));
            tests++;
            if ({RowSelect_O, FrameStrobe_O, Busy_O} !== 7'd0) begin
                $display("FAIL t5_post_reset: got row=%0d strb=%b busy=%b, expected all 0",
                         RowSelect_O, FrameStrobe_O, Busy_O); fails++;
            end
        end
        put(SYNC);
        tests++;
        if (Busy_O !== 1'b1) begin
            $display("FAIL t5_resync: got busy=%b, expected 1", Busy_O); fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [26];
        logic [4:0]  saddr [2];
        logic [4:0]  srow  [2];
        logic [4:0]  prev_row = 5'd0;
        logic        rdy;
        int idx = 0, ready_low = 0, nstrb = 0, t_first = -1, t_second = -1;
        words[0]  = 32'h1;
        words[13] = 32'h2;
        for (int i = 0; i < 12; i++) begin
            words[1 + i]  = 32'h400 + 32'(i);
            words[14 + i] = 32'h500 + 32'(i);
        end
        saddr[0] = 5'd0; saddr[1] = 5'd0; srow[0] = 5'd0; srow[1] = 5'd0;
        WordValid_I = 1'b1;
        WordData_I  = words[0];
        for (int c = 0; c < 34; c++) begin
            rdy = WordReady_O;
            if (!rdy) ready_low++;
            tick();
            if (FrameStrobe_O) begin
                if (nstrb < 2) begin
                    saddr[nstrb] = FrameAddr_O;
                    srow[nstrb]  = prev_row;
                end
                nstrb++;
            end
            prev_row = RowSelect_O;
            if (rdy && WordValid_I) begin
                if (idx == 0)  t_first  = c;
                if (idx == 13) t_second = c;
                idx++;
                if (idx < 26) WordData_I = words[idx];
                else          WordValid_I = 1'b0;
            end
        end
        WordValid_I = 1'b0;
        tests++;
        if (idx != 26 || nstrb != 2) begin
            $display("FAIL t6_counts: got accepted=%0d strobes=%0d, expected accepted=26 strobes=2", idx, nstrb); fails++;
        end
        tests++;
        if (saddr[0] !== 5'd1 || saddr[1] !== 5'd2) begin
            $display("FAIL t6_addrs: got %0d,%0d, expected 1,2", saddr[0], saddr[1]); fails++;
        end
        tests++;
        if (srow[0] !== 5'd12 || srow[1] !== 5'd12) begin
            $display("FAIL t6_strobe_after_row12: got prev rows %0d,%0d, expected 12,12", srow[0], srow[1]); fails++;
        end
        tests++;
        if (ready_low != 2) begin
            $display("FAIL t6_ready_low: got %0d cycles, expected 2", ready_low); fails++;
        end
        tests++;
        if (t_second - t_first != 14) begin
            $display("FAIL t6_frame_period: got %0d cycles, expected 14", t_second - t_first); fails++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gaps();
        test_bad_addr();
        test_desync();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
